ps2_frame_receiver: RTL

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_frame_receiver.sv | 112 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame length, error codes, FSM encoding and the
// scan codes the downstream key decoder listens for.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_START   = 2'b01;
  localparam logic [1:0] ERR_PARITY  = 2'b10;
  localparam logic [1:0] ERR_STOP    = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 pins, debounces the clock and flags each falling edge
// together with the data bit captured when the raw clock actually fell.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic bit_edge,
  output logic bit_data
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [CW-1:0]         stable_cnt;
  logic                  clk_filt;
  logic                  clk_filt_q;
  logic [FILTER_LEN-1:0] data_dly;

  // Everything resets high so an idle bus never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      stable_cnt <= '0;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      data_dly   <= '1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt   <= clk_sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      // Data lags by the filter depth so the bit seen at the edge is the one
      // present when the raw clock went low.
      data_dly[0] <= data_sync[1];
      for (int i = 1; i < FILTER_LEN; i++) begin
        data_dly[i] <= data_dly[i-1];
      end
    end
  end

  assign bit_edge = clk_filt_q & ~clk_filt;
  assign bit_data = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: collects 11-bit frames, checks start,
// odd parity and stop, and reports either a byte or an error cause.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic          bit_edge;
  logic          bit_data;
  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift_reg;
  logic [IW-1:0] idle_cnt;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bit_edge (bit_edge),
    .bit_data (bit_data)
  );

  // The verdict is registered on the stop-bit edge, so the pulses and the
  // rx_data update are visible during the single REPORT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      idle_cnt  <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      err_code  <= ERR_TIMEOUT;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (bit_edge) begin
            if (!bit_data) begin
              state   <= ST_SHIFT;
              bit_cnt <= 4'd1;
            end else begin
              rx_err   <= 1'b1;
              err_code <= ERR_START;
            end
          end
        end
        ST_SHIFT: begin
          if (bit_edge) begin
            idle_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state <= ST_REPORT;
              // shift_reg now holds data[7:0] in [7:0] and parity in [8].
              if (!odd_parity_ok(shift_reg[7:0], shift_reg[8])) begin
                rx_err   <= 1'b1;
                err_code <= ERR_PARITY;
              end else if (!bit_data) begin
                rx_err   <= 1'b1;
                err_code <= ERR_STOP;
              end else begin
                rx_data  <= shift_reg[7:0];
                rx_valid <= 1'b1;
              end
            end else begin
              shift_reg <= {bit_data, shift_reg[8:1]};
            end
          end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
            rx_err   <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule
